// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side signals of the hazard controller.
// The master drives the pipeline inputs and the slave is the controller.
interface hazard_ctrl_if;
   logic [4:0]  rs1FD;
   logic [4:0]  rs2FD;
   logic        rs2FD_used;
   logic [4:0]  rdDX;
   logic        loadDX;
   logic [4:0]  wb_writeReg;
   logic        ctrl_writeEnable;
   logic        br_taken;
   logic        md_start;
   logic        md_done;
   logic        stallA;
   logic        stallPC;
   logic        flushFD;
   logic        flushDX;
   logic        highFD1;
   logic        highFD2;
   logic        md_abort;
   logic        md_timeout;
   logic [15:0] stall_cnt;

   modport master (
      output rs1FD, rs2FD, rs2FD_used, rdDX, loadDX, wb_writeReg, ctrl_writeEnable,
             br_taken, md_start, md_done,
      input  stallA, stallPC, flushFD, flushDX, highFD1, highFD2, md_abort, md_timeout, stall_cnt
   );
   modport slave (
      input  rs1FD, rs2FD, rs2FD_used, rdDX, loadDX, wb_writeReg, ctrl_writeEnable,
             br_taken, md_start, md_done,
      output stallA, stallPC, flushFD, flushDX, highFD1, highFD2, md_abort, md_timeout, stall_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, write-back bypass select, redirect flush and
// multiply/divide wait control for a two-stage-decode pipeline.
module hazard_ctrl #(
   parameter int MD_MAX    = 34,
   parameter int FLUSH_CYC = 1
) (
   input logic          clock,
   input logic          aclr,
   hazard_ctrl_if.slave bus
);
   typedef enum logic [1:0] {RUN, FLUSH, MDWAIT} state_t;
   localparam logic [1:0] FL_LD  = 2'(FLUSH_CYC - 1);
   localparam logic [5:0] MD_LIM = 6'(MD_MAX);
   state_t      r_state, w_next;
   logic [1:0]  r_fcnt, w_fcnt;
   logic [5:0]  r_mcnt, w_mcnt;
   logic        r_timeout, w_to_set;
   logic [15:0] r_scnt;
   logic        w_luse, w_stall, w_ffd, w_fdx, w_abort;

   assign w_luse = bus.loadDX && (bus.rdDX != 5'd0) &&
                   ((bus.rdDX == bus.rs1FD) || (bus.rs2FD_used && (bus.rdDX == bus.rs2FD)));

   // A redirect overrides every state, including an in-flight multiply/divide.
   always_comb begin
      w_next   = r_state;
      w_fcnt   = r_fcnt;
      w_mcnt   = r_mcnt;
      w_stall  = 1'b0;
      w_ffd    = 1'b0;
      w_fdx    = 1'b0;
      w_abort  = 1'b0;
      w_to_set = 1'b0;
      if (bus.br_taken) begin
         w_ffd   = 1'b1;
         w_fdx   = 1'b1;
         w_abort = (r_state == MDWAIT);
         w_next  = FLUSH;
         w_fcnt  = FL_LD;
      end else begin
         case (r_state)
            RUN: begin
               if (bus.md_start) begin
                  w_stall = 1'b1;
                  w_next  = MDWAIT;
                  w_mcnt  = 6'd1;
               end else begin
                  w_stall = w_luse;
               end
            end
            FLUSH: begin
               w_ffd  = 1'b1;
               w_next = (r_fcnt == 2'd0) ? RUN : FLUSH;
               w_fcnt = (r_fcnt == 2'd0) ? r_fcnt : r_fcnt - 2'd1;
            end
            MDWAIT: begin
               if (bus.md_done) begin
                  w_next = RUN;
               end else if (r_mcnt == MD_LIM) begin
                  w_to_set = 1'b1;
                  w_next   = RUN;
               end else begin
                  w_stall = 1'b1;
                  w_mcnt  = r_mcnt + 6'd1;
               end
            end
            default: w_next = RUN;
         endcase
      end
   end

   always_ff @(posedge clock or negedge aclr) begin
      if (!aclr) begin
         r_state   <= RUN;
         r_fcnt    <= 2'd0;
         r_mcnt    <= 6'd0;
         r_timeout <= 1'b0;
         r_scnt    <= 16'd0;
      end else begin
         r_state   <= w_next;
         r_fcnt    <= w_fcnt;
         r_mcnt    <= w_mcnt;
         r_timeout <= r_timeout | w_to_set;
         if (w_stall && (r_scnt != 16'hFFFF)) r_scnt <= r_scnt + 16'd1;
      end
   end

   // Control outputs are forced low while reset is held; bypass selects stay live.
   assign bus.stallA     = aclr & w_stall;
   assign bus.stallPC    = aclr & w_stall;
   assign bus.flushFD    = aclr & w_ffd;
   assign bus.flushDX    = aclr & w_fdx;
   assign bus.md_abort   = aclr & w_abort;
   assign bus.md_timeout = r_timeout;
   assign bus.stall_cnt  = r_scnt;
   assign bus.highFD1    = bus.ctrl_writeEnable && (bus.wb_writeReg != 5'd0) &&
                           (bus.wb_writeReg == bus.rs1FD);
   assign bus.highFD2    = bus.ctrl_writeEnable && (bus.wb_writeReg != 5'd0) &&
                           bus.rs2FD_used && (bus.wb_writeReg == bus.rs2FD);
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random stimulus against a cycle-level reference
// model; expected outputs are queued by the driver and checked by a monitor.
module tb_hazard_ctrl;
   localparam int MD_MAX    = 16;
   localparam int FLUSH_CYC = 2;

   typedef struct packed {
      logic [4:0] rs1, rs2, rd, wr;
      logic used, ld, we, br, ms, md, rstn;
   } stim_t;

   typedef struct packed {
      logic sa, sp, ff, fd, h1, h2, ab, to;
      logic [15:0] sc;
   } out_t;

   logic clock = 1'b0;
   logic aclr  = 1'b0;
   hazard_ctrl_if bus ();

   hazard_ctrl #(.MD_MAX(MD_MAX), .FLUSH_CYC(FLUSH_CYC)) dut (
      .clock(clock),
      .aclr (aclr),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   out_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc_n  = 0;

   // Reference model: remaining flush cycles, multiply/divide age, sticky timeout, stall total.
   int flush_left = 0;
   bit md_busy    = 0;
   int md_age     = 0;
   bit to_sticky  = 0;
   int stalls     = 0;

   function automatic stim_t idle();
      stim_t s = '0;
      s.rstn = 1'b1;
      return s;
   endfunction

   function automatic out_t model(input stim_t s);
      out_t e = '0;
      bit hit;
      e.h1 = s.we && s.wr != 0 && s.wr == s.rs1;
      e.h2 = s.we && s.wr != 0 && s.used && s.wr == s.rs2;
      hit  = s.ld && s.rd != 0 && (s.rd == s.rs1 || (s.used && s.rd == s.rs2));
      if (!s.rstn) begin
         flush_left = 0;
         md_busy    = 0;
         md_age     = 0;
         to_sticky  = 0;
         stalls     = 0;
         return e;
      end
      e.to = to_sticky;
      e.sc = 16'(stalls);
      if (s.br) begin
         e.ff = 1;
         e.fd = 1;
         e.ab = md_busy;
         md_busy    = 0;
         flush_left = FLUSH_CYC;
      end else if (md_busy) begin
         if (s.md) md_busy = 0;
         else if (md_age == MD_MAX) begin
            to_sticky = 1;
            md_busy   = 0;
         end else begin
            e.sa = 1;
            md_age++;
         end
      end else if (flush_left > 0) begin
         e.ff = 1;
         flush_left--;
      end else if (s.ms) begin
         e.sa    = 1;
         md_busy = 1;
         md_age  = 1;
      end else if (hit) begin
         e.sa = 1;
      end
      e.sp = e.sa;
      if (e.sa && stalls < 65535) stalls++;
      return e;
   endfunction

   task automatic cyc(input stim_t s);
      @(posedge clock);
      #1;
      aclr                 = s.rstn;
      bus.rs1FD            = s.rs1;
      bus.rs2FD            = s.rs2;
      bus.rs2FD_used       = s.used;
      bus.rdDX             = s.rd;
      bus.loadDX           = s.ld;
      bus.wb_writeReg      = s.wr;
      bus.ctrl_writeEnable = s.we;
      bus.br_taken         = s.br;
      bus.md_start         = s.ms;
      bus.md_done          = s.md;
      q.push_back(model(s));
   endtask

   task automatic idles(input int n);
      for (int i = 0; i < n; i++) cyc(idle());
   endtask

   always @(negedge clock) begin
      out_t e, a;
      cyc_n++;
      if (q.size() > 0) begin
         e = q.pop_front();
         a = {bus.stallA, bus.stallPC, bus.flushFD, bus.flushDX, bus.highFD1, bus.highFD2,
              bus.md_abort, bus.md_timeout, bus.stall_cnt};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL outputs cycle %0d: got sa%b sp%b ff%b fd%b h1%b h2%b ab%b to%b sc%0d expected sa%b sp%b ff%b fd%b h1%b h2%b ab%b to%b sc%0d",
                     cyc_n, a.sa, a.sp, a.ff, a.fd, a.h1, a.h2, a.ab, a.to, a.sc,
                     e.sa, e.sp, e.ff, e.fd, e.h1, e.h2, e.ab, e.to, e.sc);
         end
      end
   end

   initial begin
      stim_t s;
      bus.rs1FD = '0; bus.rs2FD = '0; bus.rs2FD_used = 0; bus.rdDX = '0; bus.loadDX = 0;
      bus.wb_writeReg = '0; bus.ctrl_writeEnable = 0; bus.br_taken = 0; bus.md_start = 0; bus.md_done = 0;
      s = idle(); s.rstn = 0;
      cyc(s); cyc(s);
      idles(2);
      // load-use
      s = idle(); s.ld = 1; s.rd = 5; s.rs1 = 5; cyc(s);
      s.rd = 0; cyc(s);
      s = idle(); s.ld = 1; s.rd = 5; s.rs1 = 1; s.rs2 = 5; s.used = 0; cyc(s);
      s.used = 1; cyc(s);
      // write-back bypass
      s = idle(); s.we = 1; s.wr = 7; s.rs1 = 7; s.rs2 = 7; s.used = 1; cyc(s);
      s.wr = 0; cyc(s);
      s.wr = 7; s.used = 0; cyc(s);
      // redirect, alone and together with a load-use hit
      s = idle(); s.br = 1; cyc(s);
      idles(4);
      s = idle(); s.br = 1; s.ld = 1; s.rd = 3; s.rs1 = 3; cyc(s);
      s.br = 0; cyc(s); cyc(s); cyc(s);
      // multiply/divide completing, then timing out
      s = idle(); s.rstn = 0; cyc(s);
      s = idle(); s.ms = 1; cyc(s);
      idles(9);
      s = idle(); s.md = 1; cyc(s);
      idles(2);
      s = idle(); s.ms = 1; cyc(s);
      idles(MD_MAX + 3);
      // redirect colliding with md_done in the fourth wait cycle
      s = idle(); s.ms = 1; cyc(s);
      idles(3);
      s = idle(); s.br = 1; s.md = 1; cyc(s);
      idles(3);
      // reset in the middle of a wait
      s = idle(); s.ms = 1; cyc(s);
      idles(3);
      s = idle(); s.rstn = 0; cyc(s); cyc(s);
      idles(3);
      for (int i = 0; i < 3000; i++) begin
         s.rs1  = 5'($urandom_range(0, 3));
         s.rs2  = 5'($urandom_range(0, 3));
         s.rd   = 5'($urandom_range(0, 3));
         s.wr   = 5'($urandom_range(0, 3));
         s.used = 1'($urandom_range(0, 1));
         s.ld   = 1'($urandom_range(0, 1));
         s.we   = 1'($urandom_range(0, 1));
         s.br   = ($urandom_range(0, 9) == 0);
         s.ms   = ($urandom_range(0, 5) == 0);
         s.md   = ($urandom_range(0, 11) == 0);
         s.rstn = ($urandom_range(0, 99) != 0);
         cyc(s);
      end
      @(negedge clock);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, required 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
